// File: rtl/busy_arbiter_pkg.sv
// busy_arbiter shared constants: FSM encodings and counter widths.
// Build option: BUSYARB_GAP_EN adds the post-run idle guard.
package busy_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam int CNT_W = 16;
  localparam int GAP_W = 8;

endpackage

// File: rtl/busy_arbiter_if.sv
// busy_arbiter requester/arbiter bundle.
// master = requester side, slave = arbiter side.
interface busy_arbiter_if
  import busy_arbiter_pkg::*;
#(
  parameter int NREQ = 4
);

  logic [NREQ-1:0]  i_req;
  logic [NREQ-1:0]  o_grant;
  logic             o_busy;
  logic [NREQ-1:0]  o_done;
  logic [CNT_W-1:0] o_count;

  modport master (
    output i_req,
    input  o_grant,
    input  o_busy,
    input  o_done,
    input  o_count
  );

  modport slave (
    input  i_req,
    output o_grant,
    output o_busy,
    output o_done,
    output o_count
  );

endinterface

// File: rtl/busy_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, scans upward from i_ptr.
// Lowest offset from the pointer wins; wraps at NREQ-1 -> 0.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic            o_any,
  output logic [PW-1:0]   o_idx,
  output logic [NREQ-1:0] o_onehot
);

  logic [PW:0]   sum;
  logic [PW-1:0] cand;

  always_comb begin
    o_any    = 1'b0;
    o_idx    = '0;
    o_onehot = '0;
    sum      = '0;
    cand     = '0;
    // walk offsets high to low so the nearest hit overwrites
    for (int off = NREQ - 1; off >= 0; off--) begin
      sum = {1'b0, i_ptr} + (PW+1)'(off);
      if (sum >= (PW+1)'(NREQ))
        sum = sum - (PW+1)'(NREQ);
      cand = sum[PW-1:0];
      if (i_req[cand]) begin
        o_any = 1'b1;
        o_idx = cand;
      end
    end
    if (o_any)
      o_onehot = NREQ'(1) << o_idx;
  end

endmodule

// File: rtl/busy_arbiter.sv
// busy_arbiter: round-robin owner of a fixed-length countdown resource.
// Option: define BUSYARB_GAP_EN for GAP idle cycles after each run.
module busy_arbiter
  import busy_arbiter_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int MAX_AMOUNT = 22,
  parameter int GAP        = 2
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  busy_arbiter_if.slave  bus
);

  localparam int PW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
    $error("busy_arbiter: NREQ must be 2..16");
  end
  if (MAX_AMOUNT < 2 || MAX_AMOUNT > 65535) begin : g_bad_max
    $error("busy_arbiter: MAX_AMOUNT must be 2..65535");
  end
  if (GAP < 1 || GAP > 255) begin : g_bad_gap
    $error("busy_arbiter: GAP must be 1..255");
  end

`ifdef BUSYARB_GAP_EN
  localparam logic [1:0] ST_END = ST_GAP;
  logic [GAP_W-1:0] gap_cnt;
`else
  localparam logic [1:0] ST_END = ST_IDLE;
`endif

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [NREQ-1:0]  grant;
  logic [NREQ-1:0]  done;
  logic [PW-1:0]    ptr;

  logic             any;
  logic [PW-1:0]    pick;
  logic [NREQ-1:0]  pick_oh;
  logic             owner_req;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .i_req    (bus.i_req),
    .i_ptr    (ptr),
    .o_any    (any),
    .o_idx    (pick),
    .o_onehot (pick_oh)
  );

  assign owner_req = |(bus.i_req & grant);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      grant <= '0;
      done  <= '0;
      ptr   <= '0;
`ifdef BUSYARB_GAP_EN
      gap_cnt <= '0;
`endif
    end else begin
      done <= '0;
      case (state)
        ST_IDLE: begin
          if (any) begin
            grant <= pick_oh;
            cnt   <= CNT_W'(MAX_AMOUNT - 1);
            ptr   <= (pick == PW'(NREQ - 1)) ? '0 : pick + PW'(1);
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // owner dropping its request is an abort: no done pulse
          if (!owner_req || cnt == CNT_W'(1)) begin
            if (owner_req)
              done <= grant;
            cnt   <= '0;
            grant <= '0;
            state <= ST_END;
`ifdef BUSYARB_GAP_EN
            gap_cnt <= GAP_W'(GAP);
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
`ifdef BUSYARB_GAP_EN
        ST_GAP: begin
          if (gap_cnt <= GAP_W'(1))
            state <= ST_IDLE;
          else
            gap_cnt <= gap_cnt - GAP_W'(1);
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_grant = grant;
  assign bus.o_done  = done;
  assign bus.o_count = cnt;
  assign bus.o_busy  = (cnt != '0);

`ifdef FORMAL
  a_onehot: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    $onehot0(grant));
  a_busy: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    bus.o_busy == (grant != '0));
  a_step: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (state == ST_RUN && owner_req && cnt != CNT_W'(1))
      |=> cnt == $past(cnt) - CNT_W'(1));
  m_hold: assume property (@(posedge i_clk) disable iff (!i_reset_n)
    (state == ST_RUN) |-> owner_req);
`endif

endmodule

// File: tb/tb_busy_arbiter.sv
// tb_busy_arbiter: directed + random stimulus vs. a cycle-level model.
// Honours BUSYARB_GAP_EN the same way the design does.
module tb_busy_arbiter;

  localparam int NREQ = 4;
  localparam int MAXA = 22;
  localparam int GAP  = 2;
`ifdef BUSYARB_GAP_EN
  localparam int M_GAP = GAP;
`else
  localparam int M_GAP = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  busy_arbiter_if #(.NREQ(NREQ)) bus ();

  busy_arbiter #(
    .NREQ       (NREQ),
    .MAX_AMOUNT (MAXA),
    .GAP        (GAP)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int m_owner;
  int m_cnt;
  int m_ptr;
  int m_gap;
  logic [NREQ-1:0] m_done;

  logic [NREQ-1:0] prev_grant;
  logic [NREQ-1:0] order[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_ptr   = 0;
    m_gap   = 0;
    m_done  = '0;
  endtask

  task automatic model_step(input logic [NREQ-1:0] r);
    logic [1:0] ix;
    logic [1:0] ow;
    bit found;
    m_done = '0;
    if (m_owner >= 0) begin
      ow = 2'(m_owner);
      if (!r[ow] || m_cnt == 1) begin
        if (r[ow]) m_done = NREQ'(1) << m_owner;
        m_owner = -1;
        m_cnt   = 0;
        m_gap   = M_GAP;
      end else begin
        m_cnt = m_cnt - 1;
      end
    end else if (m_gap > 0) begin
      m_gap = m_gap - 1;
    end else begin
      found = 0;
      for (int k = 0; k < NREQ; k++) begin
        ix = 2'((m_ptr + k) % NREQ);
        if (!found && r[ix]) begin
          found   = 1;
          m_owner = int'(ix);
          m_cnt   = MAXA - 1;
          m_ptr   = (int'(ix) + 1) % NREQ;
        end
      end
    end
  endtask

  task automatic compare();
    logic [NREQ-1:0] eg;
    eg = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
    chk("grant", 32'(bus.o_grant), 32'(eg));
    chk("done",  32'(bus.o_done),  32'(m_done));
    chk("count", 32'(bus.o_count), 32'(m_cnt));
    chk("busy",  32'(bus.o_busy),  32'(m_cnt != 0));
  endtask

  // one clock: model follows the edge, outputs checked 1ns later,
  // then requesters drop on their own done
  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(bus.i_req);
    #1;
    compare();
    if (bus.o_grant != '0 && prev_grant == '0)
      order.push_back(bus.o_grant);
    prev_grant = bus.o_grant;
    bus.i_req = bus.i_req & ~bus.o_done;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_req = '0;
    model_reset();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (bus.i_req != '0 && n < limit) begin
      step();
      n++;
    end
    chk("drain", 32'(bus.i_req == '0), 32'd1);
  endtask

  task automatic run_to_count(input int val, input int limit);
    int n;
    n = 0;
    while (bus.o_count != 16'(val) && n < limit) begin
      step();
      n++;
    end
    chk("reach_count", 32'(bus.o_count), 32'(val));
  endtask

  initial begin
    bus.i_req = '0;
    prev_grant = '0;
    model_reset();
    #1;
    do_reset();

    // single requester
    bus.i_req = 4'b0100;
    order.delete();
    drain(40);
    chk("single_n", 32'(order.size()), 32'd1);
    if (order.size() > 0) chk("single_g", 32'(order[0]), 32'h4);

    // fairness from a fresh pointer
    do_reset();
    order.delete();
    bus.i_req = 4'b1111;
    drain(150);
    chk("fair_n", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4 && i < order.size(); i++)
      chk("fair_order", 32'(order[i]), 32'(1 << i));

    // wrap: pointer left at 3 by serving requester 2
    do_reset();
    bus.i_req = 4'b0100;
    drain(40);
    order.delete();
    bus.i_req = 4'b1001;
    drain(80);
    chk("wrap_n", 32'(order.size()), 32'd2);
    if (order.size() > 1) begin
      chk("wrap_first",  32'(order[0]), 32'h8);
      chk("wrap_second", 32'(order[1]), 32'h1);
    end

    // abort: owner withdraws mid-run
    bus.i_req = 4'b0001;
    run_to_count(10, 40);
    bus.i_req = '0;
    step();
    chk("abort_grant", 32'(bus.o_grant), 32'd0);
    chk("abort_count", 32'(bus.o_count), 32'd0);
    step();
    chk("abort_done", 32'(bus.o_done), 32'd0);
    repeat (M_GAP + 1) step();

    // asynchronous reset mid-run; pointer must return to 0
    bus.i_req = 4'b0001;
    run_to_count(5, 40);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_grant", 32'(bus.o_grant), 32'd0);
    chk("arst_busy",  32'(bus.o_busy),  32'd0);
    model_reset();
    bus.i_req = 4'b0011;
    step();
    rst_n = 1'b1;
    step();
    chk("arst_prio", 32'(bus.o_grant), 32'h1);
    drain(100);

    // random traffic with occasional aborts
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.i_req[i] && $urandom_range(0, 3) == 0)
          bus.i_req[i] = 1'b1;
        else if (m_owner == i && $urandom_range(0, 63) == 0)
          bus.i_req[i] = 1'b0;
      end
    end
    bus.i_req = '0;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
